stopwatch_ctrl: RTL and testbench

//  Control and sequencing block for the stopwatch counter/display datapath.

---
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key debounce, IDLE/RUN/PAUSE sequencing, 1 ms tick
// generation, counter clear, display load enable and status LEDs.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE = 10000000,
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic clk,
    input  logic key_reset,
    input  logic key_start_pause,
    input  logic key_display_stop,
    output logic tick,
    output logic count_en,
    output logic count_clr,
    output logic disp_load,
    output logic led0,
    output logic led1,
    output logic led2,
    output logic led3
);

    localparam int unsigned NKEY = 2;
    localparam int unsigned HW   = $clog2(DEBOUNCE + 1);
    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned KSP  = 0;
    localparam int unsigned KDS  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic [NKEY-1:0] key_raw;
    logic [NKEY-1:0] sync1;
    logic [NKEY-1:0] sync2;
    logic [HW-1:0]   hi_cnt [NKEY];
    logic [NKEY-1:0] press;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nxt;
    logic            frozen;
    logic            frozen_nxt;
    logic            tick_nxt;
    logic            led3_nxt;

    assign key_raw = {key_display_stop, key_start_pause};

    // Synchronize both keys and count consecutive synced-high cycles (saturating).
    always_ff @(posedge clk) begin
        if (!key_reset) begin
            sync1 <= '1;
            sync2 <= '1;
            for (int k = 0; k < NKEY; k++) begin
                hi_cnt[k] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int k = 0; k < NKEY; k++) begin
                if (!sync2[k]) begin
                    hi_cnt[k] <= '0;
                end else if (hi_cnt[k] != HW'(DEBOUNCE)) begin
                    hi_cnt[k] <= hi_cnt[k] + HW'(1);
                end
            end
        end
    end

    // A press is accepted only after a full stable-high interval.
    always_comb begin
        press = '0;
        for (int k = 0; k < NKEY; k++) begin
            press[k] = !sync2[k] && (hi_cnt[k] == HW'(DEBOUNCE));
        end
    end

    // State register; IDLE is only re-entered through reset.
    always_ff @(posedge clk) begin
        if (!key_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic driven by the start/pause press.
    always_comb begin
        state_nxt = state;
        if (press[KSP]) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Prescaler, tick and freeze next values, all judged on the pre-edge state.
    always_comb begin
        presc_nxt  = presc;
        tick_nxt   = 1'b0;
        led3_nxt   = led3;
        frozen_nxt = frozen;
        if (state == ST_IDLE && press[KSP]) begin
            presc_nxt = '0;
        end else if (state == ST_RUN && !press[KSP]) begin
            if (presc == PW'(TICK_DIV - 1)) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;
                led3_nxt  = !led3;
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end
        if (press[KDS] && state != ST_IDLE) begin
            frozen_nxt = !frozen;
        end
    end

    // Registered datapath state and outputs.
    always_ff @(posedge clk) begin
        if (!key_reset) begin
            presc     <= '0;
            frozen    <= 1'b0;
            tick      <= 1'b0;
            count_en  <= 1'b0;
            count_clr <= 1'b1;
            disp_load <= 1'b1;
            led0      <= 1'b0;
            led1      <= 1'b0;
            led2      <= 1'b0;
            led3      <= 1'b0;
        end else begin
            presc     <= presc_nxt;
            frozen    <= frozen_nxt;
            tick      <= tick_nxt;
            count_en  <= (state_nxt == ST_RUN);
            count_clr <= 1'b0;
            disp_load <= !frozen_nxt;
            led0      <= (state_nxt == ST_RUN);
            led1      <= (state_nxt == ST_PAUSE);
            led2      <= frozen_nxt;
            led3      <= led3_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with literal expectations plus
// randomized key activity, all checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned TICK_DIV = 5;

    logic clk = 1'b0;
    logic key_reset = 1'b0;
    logic key_start_pause = 1'b1;
    logic key_display_stop = 1'b1;
    logic tick, count_en, count_clr, disp_load, led0, led1, led2, led3;
    logic [7:0] dut_v;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit  m_valid = 1'b0;
    int  m_mode  = 0;        // 0 idle, 1 run, 2 pause
    int  m_cnt   = 0;        // counting RUN cycles since start
    bit  m_tick  = 1'b0;
    bit  m_clr   = 1'b1;
    bit  m_frozen = 1'b0;
    bit  sp_q[$];
    bit  ds_q[$];
    int  sp_run = 0;
    int  ds_run = 0;
    logic [7:0] exp_v;

    logic sp_v, ds_v;
    int   sp_left, ds_left, guard;

    stopwatch_ctrl #(
        .DEBOUNCE(DEBOUNCE),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk             (clk),
        .key_reset       (key_reset),
        .key_start_pause (key_start_pause),
        .key_display_stop(key_display_stop),
        .tick            (tick),
        .count_en        (count_en),
        .count_clr       (count_clr),
        .disp_load       (disp_load),
        .led0            (led0),
        .led1            (led1),
        .led2            (led2),
        .led3            (led3)
    );

    always #5 clk = ~clk;

    assign dut_v = {tick, count_en, count_clr, disp_load, led3, led2, led1, led0};

    // Model: keys seen two edges late; a press needs DEBOUNCE prior high samples.
    always @(posedge clk) begin
        bit sp_del, ds_del, ev_sp, ev_ds;
        if (!key_reset) begin
            m_valid = 1'b1;
            m_mode = 0; m_cnt = 0; m_tick = 1'b0; m_clr = 1'b1; m_frozen = 1'b0;
            sp_q = '{1'b1, 1'b1};
            ds_q = '{1'b1, 1'b1};
            sp_run = 0; ds_run = 0;
        end else if (m_valid) begin
            sp_del = sp_q.pop_front();
            sp_q.push_back(key_start_pause);
            ds_del = ds_q.pop_front();
            ds_q.push_back(key_display_stop);
            ev_sp = !sp_del && (sp_run >= int'(DEBOUNCE));
            ev_ds = !ds_del && (ds_run >= int'(DEBOUNCE));
            sp_run = sp_del ? sp_run + 1 : 0;
            ds_run = ds_del ? ds_run + 1 : 0;
            m_clr = 1'b0;
            m_tick = 1'b0;
            if (ev_ds && m_mode != 0) m_frozen = !m_frozen;
            if (m_mode == 1 && !ev_sp) begin
                m_cnt++;
                m_tick = (m_cnt % int'(TICK_DIV)) == 0;
            end
            if (ev_sp) begin
                if (m_mode == 0) m_cnt = 0;
                m_mode = (m_mode == 1) ? 2 : 1;
            end
        end
    end

    always_comb begin
        exp_v = {m_tick, m_mode == 1, m_clr, !m_frozen,
                 ((m_cnt / int'(TICK_DIV)) % 2) == 1, m_frozen, m_mode == 2, m_mode == 1};
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got %b expected %b (tick,en,clr,load,led3..0)",
                         $time, dut_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic sp, input logic ds);
        key_reset = r;
        key_start_pause = sp;
        key_display_stop = ds;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_n(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset and release
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        chk("reset_vec", int'(dut_v), 8'b0011_0000);
        drive(1'b1, 1'b1, 1'b1);
        chk("clr_release", int'(count_clr), 0);
        chk("clr_release_vec", int'(dut_v), 8'b0001_0000);

        // start: key low at edge N
        idle_n(9);
        drive(1'b1, 1'b0, 1'b1);
        chk("start_n", int'(count_en), 0);
        drive(1'b1, 1'b1, 1'b1);
        chk("start_n1", int'(count_en), 0);
        drive(1'b1, 1'b1, 1'b1);
        chk("start_cnt_en", int'(count_en), 1);
        chk("start_led0", int'(led0), 1);
        for (int k = 3; k <= 13; k++) begin
            drive(1'b1, 1'b1, 1'b1);
            chk("tick_sched", int'(tick), int'(k == 7 || k == 12));
            chk("led3_sched", int'(led3), int'(k >= 7 && k < 12));
        end

        // bounce: low 1, high 2, low 6 gives a single event
        drive(1'b0, 1'b1, 1'b1);
        idle_n(10);
        drive(1'b1, 1'b0, 1'b1);
        repeat (2) drive(1'b1, 1'b1, 1'b1);
        repeat (6) drive(1'b1, 1'b0, 1'b1);
        idle_n(8);
        chk("bounce_run", int'(count_en), 1);
        chk("bounce_no_pause", int'(led1), 0);

        // pause landing on prescaler == 2, then resume
        guard = 0;
        while ((m_cnt % int'(TICK_DIV)) != 0 && guard < 20) begin
            drive(1'b1, 1'b1, 1'b1);
            guard++;
        end
        chk("steer_bound", int'(guard < 20), 1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("pause_cnt_en", int'(count_en), 0);
        chk("pause_led1", int'(led1), 1);
        chk("pause_led0", int'(led0), 0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b1);
            chk("pause_tick", int'(tick), 0);
        end
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("resume_cnt_en", int'(count_en), 1);
        chk("resume_tick_m", int'(tick), 0);
        drive(1'b1, 1'b1, 1'b1);
        chk("resume_tick_m1", int'(tick), 0);
        drive(1'b1, 1'b1, 1'b1);
        chk("resume_tick_m2", int'(tick), 0);
        drive(1'b1, 1'b1, 1'b1);
        chk("resume_tick_m3", int'(tick), 1);

        // freeze ignored in IDLE, toggles in RUN
        drive(1'b0, 1'b1, 1'b1);
        idle_n(10);
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b1);
            chk("idle_freeze_ignored", int'(disp_load), 1);
        end
        drive(1'b1, 1'b0, 1'b1);
        idle_n(7);
        chk("freeze_run", int'(count_en), 1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("freeze_disp", int'(disp_load), 0);
        chk("freeze_led2", int'(led2), 1);
        idle_n(5);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("unfreeze_disp", int'(disp_load), 1);
        chk("unfreeze_led2", int'(led2), 0);

        // both keys in RUN, then a one-cycle mid-operation reset
        idle_n(6);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("both_pause", int'(led1), 1);
        chk("both_cnt_en", int'(count_en), 0);
        chk("both_disp", int'(disp_load), 0);
        chk("both_led2", int'(led2), 1);
        drive(1'b0, 1'b1, 1'b1);
        chk("midop_reset_vec", int'(dut_v), 8'b0011_0000);

        // both keys in IDLE: run starts, freeze ignored
        idle_n(10);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("idle_both_run", int'(count_en), 1);
        chk("idle_both_disp", int'(disp_load), 1);

        // randomized key activity with occasional resets
        sp_v = 1'b1; ds_v = 1'b1; sp_left = 0; ds_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (sp_left == 0) begin
                sp_v = !sp_v;
                sp_left = sp_v ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 3));
            end else begin
                sp_left--;
            end
            if (ds_left == 0) begin
                ds_v = !ds_v;
                ds_left = ds_v ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 3));
            end else begin
                ds_left--;
            end
            drive($urandom_range(0, 499) != 0, sp_v, ds_v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
